// File: rtl/hdmi_data_island_packet_assembler.sv
// HDMI data-island packet serialiser: streams header and four subpackets onto the
// TERC4 bit lanes, appending bit-serial BCH parity for each block.
module hdmi_data_island_packet_assembler #(
    parameter logic [7:0] ECC_POLY = 8'h83
) (
    input  logic         clk_pixel,
    input  logic         reset,
    input  logic         data_island_period,
    input  logic [23:0]  header,
    input  logic [223:0] sub,
    output logic         packet_load,
    output logic [8:0]   packet_data,
    output logic         packet_data_valid,
    output logic [4:0]   counter
);
    localparam int PKT_CLKS = 32;

    logic [4:0]  cnt;
    logic [23:0] hdr_sr;
    logic [55:0] sub_sr [4];
    logic [7:0]  ecc_h;
    logic [7:0]  ecc_s [4];

    logic        start_p0;
    logic [23:0] hdr_cur_p0;
    logic [55:0] sub_cur_p0 [4];
    logic [7:0]  ecc_h_base_p0;
    logic [7:0]  ecc_h_next_p0;
    logic [7:0]  ecc_s_base_p0 [4];
    logic [7:0]  ecc_s_next_p0 [4];
    logic        hdr_bit_p0;
    logic [3:0]  even_p0;
    logic [3:0]  odd_p0;
    logic [8:0]  word_p0;

    function automatic logic [7:0] ecc_step(input logic [7:0] ecc, input logic d);
        return (ecc >> 1) ^ ((ecc[0] ^ d) ? ECC_POLY : 8'h00);
    endfunction

    // Stage p0: the capture cycle reads the live inputs so index 0 needs no bubble
    always_comb begin
        start_p0      = data_island_period && (cnt == 5'd0);
        hdr_cur_p0    = start_p0 ? header : hdr_sr;
        ecc_h_base_p0 = start_p0 ? 8'h00 : ecc_h;
        hdr_bit_p0    = 1'b0;
        ecc_h_next_p0 = ecc_h_base_p0;
        even_p0       = 4'h0;
        odd_p0        = 4'h0;

        if (cnt < 5'd24) begin
            hdr_bit_p0    = hdr_cur_p0[0];
            ecc_h_next_p0 = ecc_step(ecc_h_base_p0, hdr_cur_p0[0]);
        end else begin
            // cnt in 24..31, so its low 3 bits are the parity bit index
            hdr_bit_p0 = ecc_h_base_p0[cnt[2:0]];
        end

        for (int k = 0; k < 4; k++) begin
            sub_cur_p0[k]    = start_p0 ? sub[k*56 +: 56] : sub_sr[k];
            ecc_s_base_p0[k] = start_p0 ? 8'h00 : ecc_s[k];
            ecc_s_next_p0[k] = ecc_s_base_p0[k];
            if (cnt < 5'd28) begin
                even_p0[k]       = sub_cur_p0[k][0];
                odd_p0[k]        = sub_cur_p0[k][1];
                ecc_s_next_p0[k] = ecc_step(ecc_step(ecc_s_base_p0[k], sub_cur_p0[k][0]),
                                            sub_cur_p0[k][1]);
            end else begin
                even_p0[k] = ecc_s_base_p0[k][{cnt[1:0], 1'b0}];
                odd_p0[k]  = ecc_s_base_p0[k][{cnt[1:0], 1'b1}];
            end
        end

        word_p0 = {odd_p0, even_p0, hdr_bit_p0};
    end

    assign packet_load = start_p0 && !reset;

    // Stage p1: registered lanes, shift registers and frozen-on-parity accumulators
    always_ff @(posedge clk_pixel) begin
        if (reset) begin
            cnt               <= 5'd0;
            hdr_sr            <= 24'h0;
            ecc_h             <= 8'h00;
            packet_data       <= 9'h0;
            packet_data_valid <= 1'b0;
            counter           <= 5'd0;
            for (int k = 0; k < 4; k++) begin
                sub_sr[k] <= 56'h0;
                ecc_s[k]  <= 8'h00;
            end
        end else if (data_island_period) begin
            cnt               <= (cnt == 5'(PKT_CLKS - 1)) ? 5'd0 : cnt + 5'd1;
            hdr_sr            <= hdr_cur_p0 >> 1;
            ecc_h             <= ecc_h_next_p0;
            packet_data       <= word_p0;
            packet_data_valid <= 1'b1;
            counter           <= cnt;
            for (int k = 0; k < 4; k++) begin
                sub_sr[k] <= sub_cur_p0[k] >> 2;
                ecc_s[k]  <= ecc_s_next_p0[k];
            end
        end else begin
            cnt               <= 5'd0;
            packet_data       <= 9'h0;
            packet_data_valid <= 1'b0;
            counter           <= 5'd0;
        end
    end

endmodule
